// File: rtl/pop_rpu.sv
// Pop-path engine of the SRAM-backed 4-ary BMW PIFO tree.
// Returns the root minimum, then walks one root-to-leaf path, refilling the
// popped slot at each level with the minimum of its child and decrementing
// that slot's sub-tree size.
//
// state | meaning
// IDLE  | idle, o_ready=1; i_pop issues the root read
// ROOT  | root word on i_read_data; report popped value, maybe read level 1
// POP   | write back node N at level L; descend with the child word if one was read
module pop_rpu #(
    parameter int PTW   = 16,
    parameter int MTW   = 0,
    parameter int CTW   = 10,
    parameter int ADW   = 20,
    parameter int LEVEL = 8,
    localparam int LW   = $clog2(LEVEL),
    localparam int VW   = MTW + PTW,
    localparam int SW   = CTW + MTW + PTW,
    localparam int WW   = 4 * SW
) (
    input  logic          i_clk,
    input  logic          i_arst_n,
    input  logic          i_pop,
    output logic          o_ready,
    output logic          o_pop_valid,
    output logic [VW-1:0] o_pop_data,
    output logic          o_pop_empty,
    output logic          o_read,
    input  logic [WW-1:0] i_read_data,
    output logic [LW-1:0] o_read_level,
    output logic [ADW-1:0] o_read_addr,
    output logic          o_write,
    output logic [LW-1:0] o_write_level,
    output logic [ADW-1:0] o_write_addr,
    output logic [WW-1:0] o_write_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ROOT = 2'd1,
        POP  = 2'd2
    } state_t;

    localparam logic [LW-1:0] LAST = LW'(LEVEL - 1);

    state_t         state, state_nx;
    logic [WW-1:0]  node_r, node_nx;
    logic [1:0]     port_r, port_nx;
    logic [ADW-1:0] addr_r, addr_nx;
    logic [LW-1:0]  level_r, level_nx;

    logic [1:0]     rd_port;
    logic [VW-1:0]  rd_val;
    logic [CTW-1:0] rd_size;
    logic [CTW-1:0] cur_size;
    logic [ADW-1:0] child_addr;

    function automatic logic [VW-1:0] slot_val(input logic [WW-1:0] w, input logic [1:0] i);
        return w[int'(i)*SW +: VW];
    endfunction

    function automatic logic [CTW-1:0] slot_size(input logic [WW-1:0] w, input logic [1:0] i);
        return w[int'(i)*SW+VW +: CTW];
    endfunction

    // Lowest priority wins, strict compare keeps ties on the lowest index
    function automatic logic [1:0] min_port(input logic [WW-1:0] w);
        logic [1:0] best;
        best = 2'd0;
        for (int i = 1; i < 4; i++) begin
            if (w[i*SW +: PTW] < w[int'(best)*SW +: PTW])
                best = 2'(i);
        end
        return best;
    endfunction

    function automatic logic [WW-1:0] replace_slot(input logic [WW-1:0] w, input logic [1:0] i,
                                                   input logic [CTW-1:0] size, input logic [VW-1:0] val);
        logic [WW-1:0] r;
        r = w;
        r[int'(i)*SW +: SW] = {size, val};
        return r;
    endfunction

    assign rd_port    = min_port(i_read_data);
    assign rd_val     = slot_val(i_read_data, rd_port);
    assign rd_size    = slot_size(i_read_data, rd_port);
    assign cur_size   = slot_size(node_r, port_r);
    assign child_addr = {addr_r[ADW-3:0], port_r};

    // State and walk-context registers
    always_ff @(posedge i_clk) begin
        if (!i_arst_n) begin
            state   <= IDLE;
            node_r  <= '0;
            port_r  <= '0;
            addr_r  <= '0;
            level_r <= '0;
        end else begin
            state   <= state_nx;
            node_r  <= node_nx;
            port_r  <= port_nx;
            addr_r  <= addr_nx;
            level_r <= level_nx;
        end
    end

    // Next-state, SRAM strobes and pop result
    always_comb begin
        state_nx      = state;
        node_nx       = node_r;
        port_nx       = port_r;
        addr_nx       = addr_r;
        level_nx      = level_r;
        o_ready       = 1'b0;
        o_pop_valid   = 1'b0;
        o_pop_data    = '0;
        o_pop_empty   = 1'b0;
        o_read        = 1'b0;
        o_read_level  = '0;
        o_read_addr   = '0;
        o_write       = 1'b0;
        o_write_level = '0;
        o_write_addr  = '0;
        o_write_data  = '0;

        case (state)
            IDLE: begin
                o_ready = 1'b1;
                if (i_pop) begin
                    o_read   = 1'b1;
                    state_nx = ROOT;
                end
            end

            ROOT: begin
                o_pop_valid = 1'b1;
                node_nx     = i_read_data;
                port_nx     = rd_port;
                addr_nx     = '0;
                level_nx    = '0;
                if (&rd_val[PTW-1:0]) begin
                    o_pop_empty = 1'b1;
                    o_pop_data  = '1;
                    state_nx    = IDLE;
                end else begin
                    o_pop_data = rd_val;
                    state_nx   = POP;
                    if (rd_size > CTW'(1) && LAST != '0) begin
                        o_read       = 1'b1;
                        o_read_level = LW'(1);
                        o_read_addr  = ADW'(rd_port);
                    end
                end
            end

            POP: begin
                o_write       = 1'b1;
                o_write_level = level_r;
                o_write_addr  = addr_r;
                // A zero size on a live slot means a corrupted tree; stop here too
                if (cur_size <= CTW'(1) || level_r == LAST) begin
                    o_write_data = replace_slot(node_r, port_r,
                                                (cur_size == '0) ? '0 : cur_size - CTW'(1), '1);
                    state_nx     = IDLE;
                end else begin
                    o_write_data = replace_slot(node_r, port_r, cur_size - CTW'(1), rd_val);
                    node_nx      = i_read_data;
                    port_nx      = rd_port;
                    addr_nx      = child_addr;
                    level_nx     = level_r + LW'(1);
                    if (rd_size > CTW'(1) && (level_r + LW'(1)) < LAST) begin
                        o_read       = 1'b1;
                        o_read_level = level_r + LW'(2);
                        o_read_addr  = {child_addr[ADW-3:0], rd_port};
                    end
                end
            end

            default: state_nx = IDLE;
        endcase

        // Hold every strobe low while reset is asserted
        if (!i_arst_n) begin
            o_ready     = 1'b1;
            o_pop_valid = 1'b0;
            o_pop_data  = '0;
            o_pop_empty = 1'b0;
            o_read        = 1'b0;
            o_read_level  = '0;
            o_read_addr   = '0;
            o_write       = 1'b0;
            o_write_level = '0;
            o_write_addr  = '0;
            o_write_data  = '0;
        end
    end

endmodule

// File: tb/tb_pop_rpu.sv
// Bench for pop_rpu: directed tree shapes plus randomized trees, compared
// against a path-walk model of the pop operation working on an SRAM image.
module tb_pop_rpu;

    localparam int PTW   = 16;
    localparam int MTW   = 0;
    localparam int CTW   = 10;
    localparam int ADW   = 20;
    localparam int LEVEL = 4;
    localparam int LW    = 2;
    localparam int VW    = MTW + PTW;
    localparam int SW    = CTW + VW;
    localparam int WW    = 4 * SW;

    logic           i_clk = 1'b0;
    logic           i_arst_n;
    logic           i_pop;
    logic           o_ready;
    logic           o_pop_valid;
    logic [VW-1:0]  o_pop_data;
    logic           o_pop_empty;
    logic           o_read;
    logic [WW-1:0]  i_read_data;
    logic [LW-1:0]  o_read_level;
    logic [ADW-1:0] o_read_addr;
    logic           o_write;
    logic [LW-1:0]  o_write_level;
    logic [ADW-1:0] o_write_addr;
    logic [WW-1:0]  o_write_data;

    int n_checks = 0;
    int n_errors = 0;

    logic [WW-1:0] mem [int];

    pop_rpu #(.PTW(PTW), .MTW(MTW), .CTW(CTW), .ADW(ADW), .LEVEL(LEVEL)) dut (
        .i_clk(i_clk), .i_arst_n(i_arst_n), .i_pop(i_pop), .o_ready(o_ready),
        .o_pop_valid(o_pop_valid), .o_pop_data(o_pop_data), .o_pop_empty(o_pop_empty),
        .o_read(o_read), .i_read_data(i_read_data), .o_read_level(o_read_level),
        .o_read_addr(o_read_addr), .o_write(o_write), .o_write_level(o_write_level),
        .o_write_addr(o_write_addr), .o_write_data(o_write_data)
    );

    always #5 i_clk = ~i_clk;

    function automatic int key(input int lvl, input logic [ADW-1:0] a);
        return lvl * (1 << ADW) + int'(a);
    endfunction

    function automatic logic [WW-1:0] mk_word(input logic [15:0] v3, v2, v1, v0,
                                              input logic [9:0] s3, s2, s1, s0);
        return {s3, v3, s2, v2, s1, v1, s0, v0};
    endfunction

    function automatic logic [WW-1:0] rd_mem(input int lvl, input logic [ADW-1:0] a);
        int k;
        k = key(lvl, a);
        if (mem.exists(k)) return mem[k];
        return {4{{CTW{1'b0}}, {VW{1'b1}}}};
    endfunction

    function automatic logic [VW-1:0] sval(input logic [WW-1:0] w, input int i);
        return w[i*SW +: VW];
    endfunction

    function automatic logic [CTW-1:0] ssize(input logic [WW-1:0] w, input int i);
        return w[i*SW+VW +: CTW];
    endfunction

    function automatic int argmin(input logic [WW-1:0] w);
        int best;
        logic [VW-1:0] v;
        best = 0;
        for (int i = 1; i < 4; i++) begin
            v = sval(w, i);
            if (int'(v[PTW-1:0]) < int'(sval(w, best) & {VW{1'b1}})) best = i;
        end
        return best;
    endfunction

    function automatic logic [WW-1:0] setslot(input logic [WW-1:0] w, input int i,
                                              input logic [CTW-1:0] s, input logic [VW-1:0] v);
        logic [WW-1:0] r;
        r = w;
        r[i*SW +: SW] = {s, v};
        return r;
    endfunction

    // Drive one pop and follow it cycle by cycle, serving the SRAM from mem
    task automatic run_pop(input string name);
        logic [WW-1:0]  w, c;
        logic [WW-1:0]  exp_dat [LEVEL];
        logic [ADW-1:0] exp_adr [LEVEL];
        int             exp_lvl [LEVEL];
        logic [VW-1:0]  exp_val;
        logic           exp_empty;
        logic [CTW-1:0] sz;
        logic [ADW-1:0] a;
        logic [127:0]   g;
        logic           pend;
        int             pkey, nw, lvl, p, q;
        bit             done, exp_rd;

        // reference walk over the current SRAM image
        w = rd_mem(0, '0);
        lvl = 0; a = '0; p = argmin(w); nw = 0;
        exp_val = sval(w, p);
        exp_empty = &exp_val[PTW-1:0];
        if (exp_empty) exp_val = '1;
        done = exp_empty;
        while (!done) begin
            sz = ssize(w, p);
            exp_lvl[nw] = lvl;
            exp_adr[nw] = a;
            if (sz <= 1 || lvl == LEVEL - 1) begin
                exp_dat[nw] = setslot(w, p, (sz == 0) ? '0 : sz - 1'b1, '1);
                done = 1'b1;
            end else begin
                c = rd_mem(lvl + 1, a * 4 + ADW'(p));
                q = argmin(c);
                exp_dat[nw] = setslot(w, p, sz - 1'b1, sval(c, q));
                a = a * 4 + ADW'(p);
                lvl++;
                w = c;
                p = q;
            end
            nw++;
        end

        @(negedge i_clk);
        i_pop = 1'b1;
        #1;
        n_checks++;
        if ({o_ready, o_read, o_read_level, o_read_addr} !== {1'b1, 1'b1, LW'(0), ADW'(0)}) begin
            n_errors++;
            $display("FAIL %s accept: ready/read/lvl/addr got %b %b %0d %0h want 1 1 0 0",
                     name, o_ready, o_read, o_read_level, o_read_addr);
        end
        pend = o_read;
        pkey = key(int'(o_read_level), o_read_addr);

        for (int cyc = 1; cyc <= nw + 2; cyc++) begin
            @(negedge i_clk);
            g = {$urandom, $urandom, $urandom, $urandom};
            i_read_data = (pend && mem.exists(pkey)) ? mem[pkey] :
                          (pend ? rd_mem(pkey / (1 << ADW), ADW'(pkey % (1 << ADW))) : g[WW-1:0]);
            i_pop = (cyc == nw + 2) ? 1'b0 : 1'($urandom_range(0, 1));
            #1;

            n_checks++;
            if (cyc == 1) begin
                if ({o_pop_valid, o_pop_empty, o_pop_data} !== {1'b1, exp_empty, exp_val}) begin
                    n_errors++;
                    $display("FAIL %s pop_result: valid/empty/data got %b %b %h want 1 %b %h",
                             name, o_pop_valid, o_pop_empty, o_pop_data, exp_empty, exp_val);
                end
            end else if (o_pop_valid !== 1'b0) begin
                n_errors++;
                $display("FAIL %s pop_valid cyc %0d: got %b want 0", name, cyc, o_pop_valid);
            end

            n_checks++;
            if (cyc >= 2 && cyc <= nw + 1) begin
                if ({o_write, o_write_level, o_write_addr, o_write_data} !==
                    {1'b1, LW'(exp_lvl[cyc-2]), exp_adr[cyc-2], exp_dat[cyc-2]}) begin
                    n_errors++;
                    $display("FAIL %s write cyc %0d: got %b L%0d a%0d %h want 1 L%0d a%0d %h",
                             name, cyc, o_write, o_write_level, o_write_addr, o_write_data,
                             exp_lvl[cyc-2], exp_adr[cyc-2], exp_dat[cyc-2]);
                end
            end else if (o_write !== 1'b0) begin
                n_errors++;
                $display("FAIL %s write cyc %0d: got %b want 0", name, cyc, o_write);
            end

            exp_rd = (cyc <= nw - 1);
            n_checks++;
            if (exp_rd) begin
                if ({o_read, o_read_level, o_read_addr} !== {1'b1, LW'(exp_lvl[cyc]), exp_adr[cyc]}) begin
                    n_errors++;
                    $display("FAIL %s read cyc %0d: got %b L%0d a%0d want 1 L%0d a%0d",
                             name, cyc, o_read, o_read_level, o_read_addr, exp_lvl[cyc], exp_adr[cyc]);
                end
            end else if (o_read !== 1'b0) begin
                n_errors++;
                $display("FAIL %s read cyc %0d: got %b want 0", name, cyc, o_read);
            end

            n_checks++;
            if (o_ready !== (cyc == nw + 2)) begin
                n_errors++;
                $display("FAIL %s ready cyc %0d: got %b want %b", name, cyc, o_ready, cyc == nw + 2);
            end

            if (o_write) mem[key(int'(o_write_level), o_write_addr)] = o_write_data;
            pend = o_read;
            pkey = key(int'(o_read_level), o_read_addr);
        end
    endtask

    task automatic load_full_path();
        mem.delete();
        mem[key(0, 0)]  = mk_word(16'd20, 16'd1, 16'd30, 16'd40, 10'd1, 10'd4, 10'd1, 10'd1);
        mem[key(1, 2)]  = mk_word(16'd50, 16'd60, 16'd2, 16'd70, 10'd1, 10'd1, 10'd3, 10'd1);
        mem[key(2, 9)]  = mk_word(16'd3, 16'd80, 16'd90, 16'd95, 10'd2, 10'd1, 10'd1, 10'd1);
        mem[key(3, 39)] = mk_word(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'd4, 10'd0, 10'd0, 10'd0, 10'd1);
    endtask

    task automatic test_reset();
        i_arst_n = 1'b0;
        i_pop = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge i_clk);
            #1;
            n_checks++;
            if ({o_ready, o_read, o_write, o_pop_valid} !== 4'b1000) begin
                n_errors++;
                $display("FAIL reset cyc %0d: ready/read/write/valid got %b%b%b%b want 1000",
                         k, o_ready, o_read, o_write, o_pop_valid);
            end
        end
        @(negedge i_clk);
        i_arst_n = 1'b1;
        i_pop = 1'b0;
        #1;
        n_checks++;
        if ({o_ready, o_read, o_write, o_pop_valid, o_pop_empty, o_write_data} !== {4'b1000, 1'b0, {WW{1'b0}}}) begin
            n_errors++;
            $display("FAIL reset_release: ready/read/write/valid got %b%b%b%b want 1000",
                     o_ready, o_read, o_write, o_pop_valid);
        end
    endtask

    task automatic test_leaf_refill();
        mem.delete();
        mem[key(0, 0)] = mk_word(16'hFFFF, 16'd9, 16'd3, 16'd5, 10'd0, 10'd1, 10'd2, 10'd1);
        mem[key(1, 1)] = mk_word(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'd7, 10'd0, 10'd0, 10'd0, 10'd1);
        run_pop("leaf_refill");
    endtask

    task automatic test_empty();
        mem.delete();
        mem[key(0, 0)] = mk_word(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 10'd0, 10'd0, 10'd0, 10'd0);
        run_pop("empty");
    endtask

    task automatic test_full_path();
        load_full_path();
        run_pop("full_path");
        run_pop("full_path_again");
    endtask

    task automatic test_tie();
        mem.delete();
        mem[key(0, 0)] = mk_word(16'd4, 16'd4, 16'd8, 16'd4, 10'd1, 10'd1, 10'd1, 10'd1);
        run_pop("tie");
    endtask

    task automatic test_reset_mid_walk();
        load_full_path();
        @(negedge i_clk);
        i_pop = 1'b1;
        #1;
        @(negedge i_clk);
        i_pop = 1'b0;
        i_read_data = mem[key(0, 0)];
        #1;
        @(negedge i_clk);
        i_read_data = mem[key(1, 2)];
        #1;
        @(negedge i_clk);
        i_read_data = mem[key(2, 9)];
        i_arst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            @(negedge i_clk);
            i_arst_n = 1'b1;
            #1;
            n_checks++;
            if ({o_ready, o_write, o_read, o_pop_valid} !== 4'b1000) begin
                n_errors++;
                $display("FAIL reset_mid_walk cyc %0d: ready/write/read/valid got %b%b%b%b want 1000",
                         k, o_ready, o_write, o_read, o_pop_valid);
            end
        end
    endtask

    task automatic test_random();
        logic [15:0] v [4];
        logic [9:0]  s [4];
        mem.delete();
        for (int lvl = 0; lvl < LEVEL; lvl++) begin
            for (int a = 0; a < (1 << (2 * lvl)); a++) begin
                for (int i = 0; i < 4; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        v[i] = 16'hFFFF;
                        s[i] = 10'($urandom_range(0, 1));
                    end else begin
                        v[i] = 16'($urandom_range(0, 40));
                        s[i] = 10'($urandom_range(0, 5));
                    end
                end
                mem[key(lvl, ADW'(a))] = mk_word(v[3], v[2], v[1], v[0], s[3], s[2], s[1], s[0]);
            end
        end
        for (int n = 0; n < 30; n++) run_pop("random");
    endtask

    initial begin
        i_arst_n = 1'b0;
        i_pop = 1'b0;
        i_read_data = '0;
        test_reset();
        test_leaf_refill();
        test_empty();
        test_full_path();
        test_tie();
        test_reset_mid_walk();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
